bist_sig_compactor: RTL and testbench

Output-response compactor and verdict stage for the arbiter BIST path. It sits directly downstream of the arbiter under test and consumes its 4-bit `grant_o` every clock for a fixed number of test cycles. The stream is folded into a multiple-input signature register (MISR). The final signature is compared against a golden value, and the block reports `bist_end` and `pass_fail` to the BIST controller and top level.

---
 rtl/bist_sig_compactor.sv | 92 +++++++++
 tb/tb_bist_sig_compactor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_sig_compactor.sv
// MISR output-response compactor for the arbiter BIST path: folds grant_i into a
// Galois-form signature for TEST_LEN cycles, then compares it against GOLDEN.
module bist_sig_compactor #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  POLY     = 16'h8005,
    parameter logic [WIDTH-1:0]  SEED     = 16'h0000,
    parameter int                TEST_LEN = 255,
    parameter logic [WIDTH-1:0]  GOLDEN   = 16'h0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       grant_i,
    output logic             busy,
    output logic             bist_end,
    output logic             pass_fail,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

    localparam logic [15:0] LAST = 16'(TEST_LEN - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [15:0]      cnt_q;
    logic             busy_q;
    logic             end_q;
    logic             pass_q;

    // One MISR step: shift, fold the MSB back through POLY, inject the sample.
    always_comb begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0}
              ^ (sig_q[WIDTH-1] ? POLY : '0)
              ^ {{(WIDTH-4){1'b0}}, grant_i};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sig_q <= sig_d;
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == LAST)
                        state_q <= COMPARE;
                end
                COMPARE: begin
                    pass_q  <= (sig_q == GOLDEN);
                    busy_q  <= 1'b0;
                    end_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // Restart clears the previous verdict on the same edge.
                    if (start) begin
                        state_q <= RUN;
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        end_q   <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign bist_end    = end_q;
    assign pass_fail   = pass_q;
    assign signature   = sig_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bist_sig_compactor.sv
// Scoreboard bench for bist_sig_compactor: a driver pushes the expected verdict of
// each run, a monitor pops it when bist_end rises.
module tb_bist_sig_compactor;

    localparam int          W    = 16;
    localparam logic [15:0] POLY = 16'h8005;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          T    = 20;

    // Polynomial-arithmetic view: multiply by x modulo POLY, then add the sample.
    function automatic logic [15:0] step(input logic [15:0] s, input logic [3:0] g);
        int v;
        v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ int'(POLY);
        v = v ^ int'(g);
        return v[15:0];
    endfunction

    function automatic logic [15:0] zero_sig(input int n);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = step(s, 4'h0);
        return s;
    endfunction

    localparam logic [15:0] GOLD = zero_sig(T);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  grant;
    logic        busy, bist_end, pass_fail;
    logic [15:0] signature, cycle_count;

    bist_sig_compactor #(
        .WIDTH(W), .POLY(POLY), .SEED(SEED), .TEST_LEN(T), .GOLDEN(GOLD)
    ) dut (
        .clock(clk), .reset(rst_n), .start(start), .grant_i(grant),
        .busy(busy), .bist_end(bist_end), .pass_fail(pass_fail),
        .signature(signature), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: verdict is checked on the rising edge of bist_end.
    logic prev_end = 1'b0;
    always @(negedge clk) begin
        if (bist_end && !prev_end) begin
            if (sb.size() == 0) begin
                chk("unexpected_bist_end", 1, 0);
            end else begin
                e_m = sb.pop_front();
                chk("signature", int'(signature), int'(e_m.sig));
                chk("pass_fail", int'(pass_fail), int'(e_m.pass));
                chk("cycle_count", int'(cycle_count), T);
                chk("latency", cyc, e_m.at);
            end
        end
        prev_end <= bist_end;
    end

    task automatic wait_end();
        int k;
        k = 0;
        while (!bist_end && k < 10) begin
            tick();
            k++;
        end
        if (!bist_end) chk("bist_end_timeout", 0, 1);
    endtask

    function automatic logic [15:0] model(input logic [3:0] g[$]);
        logic [15:0] s;
        s = SEED;
        foreach (g[i]) s = step(s, g[i]);
        return s;
    endfunction

    // mode 0: random grants, 1: all-zero grants (matches GOLDEN), 2: random + stray start pulses
    task automatic run(input int mode);
        logic [3:0]  g[$];
        logic [15:0] s;
        int          e0;
        for (int i = 0; i < T; i++) g.push_back(mode == 1 ? 4'h0 : 4'($urandom_range(0, 15)));
        s = model(g);
        e0 = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < T; i++) begin
            grant = g[i];
            if (mode == 2) start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        grant = 4'($urandom);
        sb.push_back('{s, (s == GOLD), e0 + T + 1});
        wait_end();
    endtask

    task automatic b2b(input int n);
        logic [3:0]  g[$];
        logic [15:0] s;
        int          e0;
        start = 1'b1;
        e0 = cyc + 1;
        tick();
        for (int r = 0; r < n; r++) begin
            g.delete();
            for (int i = 0; i < T; i++) g.push_back((r % 2 == 1) ? 4'h0 : 4'($urandom_range(0, 15)));
            s = model(g);
            for (int i = 0; i < T; i++) begin
                grant = g[i];
                tick();
            end
            sb.push_back('{s, (s == GOLD), e0 + T + 1});
            if (r == n - 1) begin
                start = 1'b0;
                wait_end();
            end else begin
                tick();
                chk("b2b_done", int'(bist_end), 1);
                e0 = cyc + 1;
                tick();
                chk("b2b_restart", int'({bist_end, busy, pass_fail}), 3'b010);
            end
        end
    endtask

    task automatic mid_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            grant = 4'($urandom_range(0, 15));
            tick();
        end
        chk("mid_count", int'(cycle_count), 10);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_sig", int'(signature), int'(SEED));
        chk("mid_rst_count", int'(cycle_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_end", int'(bist_end), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_idle_busy", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        grant = 4'h0;
        repeat (3) tick();
        chk("rst_sig", int'(signature), int'(SEED));
        chk("rst_count", int'(cycle_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_end", int'(bist_end), 0);
        chk("rst_pass", int'(pass_fail), 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("idle_hold", int'(busy), 0);
        tick();

        run(1);
        run(0);
        run(2);
        run(2);
        mid_reset();
        run(0);
        run(1);
        b2b(4);
        for (int i = 0; i < 1000; i++) run((i % 10 == 0) ? 1 : ((i % 10 == 5) ? 2 : 0));

        repeat (3) tick();
        chk("scoreboard_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
